// File: rtl/mult_defs_pkg.sv
// Shared definitions for the shift-add multiplier: state encodings and
// the default operand width, used by the controller and its bench.
`timescale 1ns/100ps
package mult_defs_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed for a down-counter that starts at w and ends at 1.
  function automatic int cnt_bits(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_add_datapath.sv
// Shift-add datapath: accumulator (with carry bit), multiplicand and
// multiplier registers, one conditional add plus a right shift per step.
// next_prod is the product the step in flight would leave in {acc, mplr};
// the controller captures it on the final step.
`timescale 1ns/100ps
module shift_add_datapath #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               load,
  input  logic               shift,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] next_prod
);

  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplr;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   shifted;

  // Add the multiplicand when the current multiplier LSB is set, then
  // shift the whole {acc, mplr} pair right by one.
  always_comb begin
    addend  = mplr[0] ? {1'b0, mcand} : '0;
    sum     = acc + addend;
    shifted = {sum, mplr} >> 1;
  end

  assign next_prod = shifted[2*WIDTH-1:0];

  // Operand capture on load, one iteration per clock on shift.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
    end else if (load) begin
      acc   <= '0;
      mcand <= a_in;
      mplr  <= b_in;
    end else if (shift) begin
      acc   <= shifted[2*WIDTH:WIDTH];
      mplr  <= shifted[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/shift_add_mult_core.sv
// Sequential unsigned shift-add multiplier controller.
// Optional build macro: ZERO_BYPASS_EN -- a start with either operand zero
// skips the iterations and completes with product 0 one cycle later.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; operands sampled on the start edge
// ST_CALC | one multiplier bit per clock, count runs WIDTH down to 1
// ST_DONE | product updated, done high for this single cycle
`timescale 1ns/100ps
module shift_add_mult_core
  import mult_defs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = cnt_bits(WIDTH);

  state_t               state;
  logic [CW-1:0]        count;
  logic                 load;
  logic                 shift;
  logic [2*WIDTH-1:0]   next_prod;

  assign load  = (state == ST_IDLE) && start;
  assign shift = (state == ST_CALC);

`ifdef ZERO_BYPASS_EN
  logic zero_op;
  assign zero_op = (a_in == '0) || (b_in == '0);
`endif

  shift_add_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .clr_n     (clr_n),
    .load      (load),
    .shift     (shift),
    .a_in      (a_in),
    .b_in      (b_in),
    .next_prod (next_prod)
  );

  // Sequencing FSM with iteration down-counter and registered outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= ST_IDLE;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
`ifdef ZERO_BYPASS_EN
            if (zero_op) begin
              state   <= ST_DONE;
              done    <= 1'b1;
              product <= '0;
            end else begin
              state <= ST_CALC;
              count <= CW'(WIDTH);
            end
`else
            state <= ST_CALC;
            count <= CW'(WIDTH);
`endif
          end
        end
        ST_CALC: begin
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            product <= next_prod;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
